// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared definitions for the multiply scheduler.
//   state_t        - scheduler FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  - default operand width in bits
package mult_sched_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_core.sv
// mult_core: shift-add unsigned multiplier datapath.
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : latch a_in/b_in, clear accumulator and step counter
//   step       : one shift-add step (conditional add, shift operands, count)
//   a_in, b_in : multiplier and multiplicand, WIDTH bits
//   last       : step counter equals WIDTH-1 (the current step is the final one)
//   product    : accumulator, 2*WIDTH bits
module mult_core
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  // One extra bit keeps the counter meaningful even for WIDTH=1.
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= {{WIDTH{1'b0}}, b_in};
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      // The multiplicand is held at double width, so the sum of all
      // partial products fits the accumulator without overflow.
      if (a_q[0]) begin
        acc_q <= acc_q + b_q;
      end
      b_q   <= b_q << 1;
      a_q   <= a_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign product = acc_q;

endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: two-requester arbiter in front of a shift-add multiplier.
//   clk, n_rst          : clock, asynchronous active-low reset
//   req_valid[1:0]      : per-requester request valid
//   req_ready[1:0]      : per-requester accept (only in IDLE, only the grantee)
//   req_a0/b0, a1/b1    : operands of requester 0 / 1
//   rsp_valid/rsp_ready : result handshake
//   rsp_id              : requester that owns the result
//   rsp_product         : unsigned product, 2*WIDTH bits
//   busy                : state is not IDLE
//   dbg_state           : current FSM state (mult_sched_pkg::state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready is a function of state and req_valid; valid must never
// depend on ready. The result holds until rsp_ready is sampled high.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   rsp_id_q;

  logic             gnt_idx;
  logic             accept;
  logic             core_load;
  logic             core_step;
  logic             core_last;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // Arbitration: a lone requester wins; under contention the one that did
  // not win last time wins.
  always_comb begin
    gnt_idx   = 1'b0;
    req_ready = 2'b00;
    case (req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant_q;
      default: gnt_idx = 1'b0;
    endcase
    // n_rst gates ready so nothing looks acceptable while reset is held.
    if (n_rst && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid & req_ready);
  assign op_a   = gnt_idx ? req_a1 : req_a0;
  assign op_b   = gnt_idx ? req_b1 : req_b0;

  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          core_load = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Returning to IDLE here leaves ready low on this edge, which is
        // what enforces the one-cycle gap between accepts.
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= gnt_idx;
        rsp_id_q     <= gnt_idx;
      end
    end
  end

  mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (core_load),
    .step    (core_step),
    .a_in    (op_a),
    .b_in    (op_b),
    .last    (core_last),
    .product (rsp_product)
  );

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; the product is 2*WIDTH bits.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state changes on its rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; a request transfers when valid and ready are both high.
- req_a0, req_b0  input  WIDTH  requester 0 multiplier and multiplicand.
- req_a1, req_b1  input  WIDTH  requester 1 multiplier and multiplicand.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  index of the requester that owns the result.
- rsp_product  output  2*WIDTH  unsigned product.
- busy  output  1  high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have three states:
- IDLE: waiting for a request.
- RUN: one shift-add step per cycle.
- DONE: result held.
REQ-004 In IDLE, the grant SHALL be computed combinationally from req_valid:
- If only one requester is valid, that requester is granted.
- If both are valid, the requester other than last_grant is granted.
REQ-005 req_ready[i] SHALL be high only in IDLE, and only for the granted requester; in RUN and DONE, req_ready SHALL be 2'b00.
REQ-006 Requesters SHALL NOT make req_valid depend on req_ready; the block SHALL NOT depend on req_ready being low to avoid a combinational loop.
REQ-007 On an accept edge, the block SHALL:
- latch the granted operands,
- set last_grant and the result id to the granted index,
- clear the accumulator and the step counter,
- enter RUN.
REQ-008 In RUN, on each cycle, the block SHALL:
- add the shifted multiplicand to the accumulator when the current multiplier LSB is 1,
- shift the multiplicand left by 1,
- shift the multiplier right by 1,
- increment the step counter.
REQ-009 After exactly WIDTH RUN cycles, the block SHALL enter DONE; rsp_valid SHALL rise WIDTH cycles after the accept edge, independent of operand values (zero operands included).
REQ-010 The accumulator SHALL be 2*WIDTH bits and SHALL never overflow; the result SHALL equal a*b unsigned, for example 4'hF*4'hF = 8'hE1.
REQ-011 In DONE, rsp_valid SHALL be high, and rsp_product and rsp_id SHALL be stable until rsp_ready is sampled high.
REQ-012 On an edge where both rsp_valid and rsp_ready are high, the block SHALL return to IDLE; no new request SHALL be accepted on that edge, giving a minimum one-cycle gap between an accept and the next accept.
REQ-013 rsp_valid SHALL be low in IDLE and in RUN.
REQ-014 Requests arriving in RUN or DONE SHALL be held off by req_ready=0 and SHALL NOT be lost; the requester keeps valid and operands stable.
REQ-015 Operand changes on the request ports after the accept edge SHALL NOT affect the result in flight.

Reset
REQ-016 Asserting n_rst low SHALL, asynchronously, set:
- state = IDLE,
- last_grant = 1, so requester 0 wins the first contended grant,
- accumulator, operand registers, counter, rsp_product, rsp_id = 0,
- rsp_valid = 0, busy = 0, req_ready = 2'b00 while in reset.
REQ-017 A reset asserted in RUN or DONE SHALL abort the operation; no response SHALL be produced for the aborted request.
REQ-018 After n_rst deasserts, the block SHALL accept a request on the first rising edge at which a request is valid.

Structure
REQ-019 A shared package mult_sched_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default-width constant.
REQ-020 The shift-add datapath SHALL be one sub-module, mult_core, comprising the operand shift registers, the accumulator and the step counter, with these controls from the FSM:
- load: latch operands, clear accumulator and counter.
- step: perform one shift-add step.
- last: step counter = WIDTH-1.
REQ-021 Arbitration and the FSM SHALL reside in mult_scheduler.

Verification
REQ-022 The bench SHALL cover these directed scenarios (WIDTH=4):
- Single request: req_valid=01, a0=3, b0=5 -> accept edge T; rsp_valid at T+4; rsp_product=8'h0F, rsp_id=0.
- Maximum operands: a1=F, b1=F, only req1 valid -> rsp_product=8'hE1, rsp_id=1, latency 4.
- Contention: both valid from reset (a0=2,b0=3; a1=4,b1=5) -> first response is id 0 with 8'h06, second is id 1 with 8'h14; with both held valid, grants alternate 0,1,0,1.
- Backpressure: rsp_ready low for 3 cycles in DONE -> rsp_valid, product and id stable; req_ready=00 throughout; IDLE on the edge after rsp_ready rises.
- Zero operand: a0=0, b0=9 -> rsp_product=8'h00, still 4-cycle latency.
- Mid-run reset: assert n_rst at the second RUN cycle -> outputs are 0 immediately; no response; the next request completes correctly.
